data_bus: RTL
=============

Name: data_bus

Overview:
- Data-side memory stage directly downstream of the single-cycle core's load/store path.
- Consumes the core's store strobe, address, store data and store size. Returns load data in the same cycle.
- Decodes the address into three targets: a word-organised data RAM with byte lanes, a UART transmitter, and a free-running cycle counter.
- Load data is returned right-aligned; the core performs sign/zero extension.

Parameters:
MEM_WORDS, 1024, data RAM depth in 32-bit words (power of two)
MMIO_BASE, 32'hFFFF_0000, base address of the MMIO register block
CLKS_PER_BIT, 868, UART bit period in i_clk cycles (>=2)

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_write  input  1  store strobe from core
i_addr  input  32  byte address for load or store
i_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
i_memsize  input  2  store size: 00 none, 01 byte, 10 half, 11 word
o_rdata  output  32  load data, combinational from i_addr
o_uart_tx  output  1  UART serial output, idle high
o_fault  output  1  sticky misaligned/unmapped-store flag

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset values:
  - o_uart_tx=1, UART state IDLE, busy=0, overrun=0.
  - Cycle counter=0, o_fault=0.
  - RAM contents are not reset.
- Address map:
  - RAM: i_addr < MEM_WORDS*4; word index i_addr[log2(MEM_WORDS)+1:2].
  - MMIO_BASE+0: UART TXDATA (write-only; reads 0).
  - MMIO_BASE+4: UART STATUS, read {30'b0, overrun, busy}. Any store here clears overrun.
  - MMIO_BASE+8: CYCLE, read-only.
  - All other addresses: loads return 0.
- Stores (qualified by i_write=1 and i_memsize!=00; i_memsize is ignored when i_write=0):
  - Byte: lane i_addr[1:0] <= i_wdata[7:0].
  - Half: requires i_addr[0]=0; lanes {i_addr[1],0}..+1 <= i_wdata[15:0].
  - Word: requires i_addr[1:0]=00.
  - Misaligned store: suppressed entirely and sets o_fault.
  - Store to unmapped address, or to CYCLE: suppressed and sets o_fault.
  - o_fault stays set until reset.
  - i_write=1 with i_memsize=00: no effect, no fault.
- Store timing: writes commit on the rising edge. A load to the same address in the same cycle returns the pre-write data. The next cycle returns the new data.
- Loads:
  - o_rdata = RAM word >> (8*i_addr[1:0]), zero-filled, purely combinational.
  - MMIO reads are right-aligned; low address bits are ignored within each register.
- CYCLE: increments by 1 every cycle after reset, wraps 32'hFFFF_FFFF -> 0.
- UART TX state machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - Format is 8N1, LSB first. Each state/bit lasts CLKS_PER_BIT cycles.
  - A store of any size to TXDATA in IDLE latches i_wdata[7:0]. The FSM enters START on the next edge; busy=1 from that edge.
  - o_uart_tx=0 in START, data bit n in DATA, 1 in STOP.
  - busy returns to 0 exactly 10*CLKS_PER_BIT cycles after entering START.
  - A TXDATA store while busy=1 is dropped and sets overrun; the frame in flight is unaffected.
  - Reset mid-frame: the line returns to 1 on the next edge and the FSM is in IDLE.
- Simultaneous events: reset has priority over every store and counter update. A STATUS store and an overrun-setting condition cannot coincide (distinct addresses).

Test Plan:
- Word store 32'hDEADBEEF @0x10, then byte stores 8'h11 @0x12 and half 16'hCAFE @0x16 -> load @0x10 = 32'hDE11BEEF, @0x12 = 32'h0000DE11, @0x14 = 32'hCAFExxxx (prior word preserved in low half); same-cycle load during store returns old data.
- Misaligned: half store @0x21 and word store @0x22 -> RAM unchanged, o_fault=1 from next cycle until i_rst; memsize=00 with i_write=1 -> no fault.
- UART, CLKS_PER_BIT=4: store 8'hA5 to MMIO_BASE -> o_uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; STATUS busy=1 for 40 cycles, then 0.
- Overrun: second TXDATA store during frame -> frame bits unchanged, STATUS=32'h3; store to STATUS -> overrun clears, reads 32'h1 while still busy.
- CYCLE: reads n at n cycles after reset release; force counter to 32'hFFFF_FFFF, one cycle later reads 0; store to CYCLE sets o_fault, value keeps counting.
- Reset mid-frame and mid-count -> o_uart_tx=1, busy=0, CYCLE=0, o_fault=0 on the cycle after i_rst; RAM contents retained.

Source files
------------

// File: rtl/data_bus.sv
// Data-side memory stage: byte-lane data RAM, UART transmitter and cycle counter
// behind one combinational load / clocked store port.
module data_bus #(
  parameter int          MEM_WORDS    = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic [31:0] o_rdata,
  output logic        o_uart_tx,
  output logic        o_fault
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          in_ram, sel_tx, sel_status, sel_cycle;
  logic          st_req, misaligned, st_ok;
  logic          ram_we, tx_we, status_we, fault_set;
  logic [3:0]    byte_en;
  logic [31:0]   lane_data;
  logic [31:0]   cycle_q;
  logic          fault_q, overrun_q, busy;

  uart_state_e   state_q, state_n;
  logic [CW-1:0] clk_cnt_q, clk_cnt_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;

  // MMIO registers decode on the word address, so low address bits are don't-care.
  assign ram_idx    = i_addr[AW+1:2];
  assign in_ram     = i_addr < RAM_BYTES;
  assign sel_tx     = i_addr[31:2] == MMIO_WORD;
  assign sel_status = i_addr[31:2] == MMIO_WORD + 30'd1;
  assign sel_cycle  = i_addr[31:2] == MMIO_WORD + 30'd2;

  assign st_req     = i_write && (i_memsize != 2'b00);
  assign misaligned = ((i_memsize == 2'b10) && i_addr[0]) ||
                      ((i_memsize == 2'b11) && (i_addr[1:0] != 2'b00));
  assign st_ok      = st_req && !misaligned;
  assign ram_we     = st_ok && in_ram;
  assign tx_we      = st_ok && sel_tx;
  assign status_we  = st_ok && sel_status;
  assign fault_set  = st_req && (misaligned || !(in_ram || sel_tx || sel_status));
  assign busy       = state_q != S_IDLE;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = i_wdata;
    unique case (i_memsize)
      2'b01: begin
        byte_en   = 4'b0001 << i_addr[1:0];
        lane_data = {4{i_wdata[7:0]}};
      end
      2'b10: begin
        byte_en   = i_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{i_wdata[15:0]}};
      end
      2'b11:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // NOTE: the RAM array has no reset; only control state is cleared by i_rst.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[ram_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (in_ram)          o_rdata = mem[ram_idx] >> {i_addr[1:0], 3'b000};
    else if (sel_status) o_rdata = {30'b0, overrun_q, busy};
    else if (sel_cycle)  o_rdata = cycle_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_q   <= '0;
      fault_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (fault_set)          fault_q   <= 1'b1;
      if (tx_we && busy)      overrun_q <= 1'b1;
      else if (status_we)     overrun_q <= 1'b0;
    end
  end

  assign o_fault = fault_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_n;
      clk_cnt_q <= clk_cnt_n;
      bit_q     <= bit_n;
      shift_q   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    clk_cnt_n = clk_cnt_q + CW'(1);
    bit_n     = bit_q;
    shift_n   = shift_q;
    unique case (state_q)
      S_IDLE: begin
        clk_cnt_n = '0;
        if (tx_we) begin
          state_n = S_START;
          shift_n = i_wdata[7:0];
        end
      end
      S_START: if (clk_cnt_q == BIT_LAST) begin
        state_n   = S_DATA;
        clk_cnt_n = '0;
        bit_n     = '0;
      end
      S_DATA: if (clk_cnt_q == BIT_LAST) begin
        clk_cnt_n = '0;
        if (bit_q == 3'd7) state_n = S_STOP;
        else               bit_n   = bit_q + 3'd1;
      end
      S_STOP: if (clk_cnt_q == BIT_LAST) begin
        state_n   = S_IDLE;
        clk_cnt_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    o_uart_tx = 1'b1;
    unique case (state_q)
      S_START: o_uart_tx = 1'b0;
      S_DATA:  o_uart_tx = shift_q[bit_q];
      default: o_uart_tx = 1'b1;
    endcase
  end

endmodule
